// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-control definitions for the 5-stage MIPS core.
// Hazard FSM encoding, stall causes, register-zero/NOP constants, control bundle.
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_JR_STALL,
        ST_MD_WAIT
    } hz_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_LU,
        CAUSE_JR,
        CAUSE_MD
    } stall_cause_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic if_id_flush;
        logic md_start;
        logic md_abort;
        logic md_err;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NOP = '0;

    function automatic logic reg_match(logic [4:0] wreg, logic [4:0] src);
        return (wreg != REG_ZERO) && (wreg == src);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and jr-on-load hazard terms.
// Writes to $0 never match, so they never produce a hazard.
import pipe_pkg::*;

module hazard_detect (
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_id_jmp_reg,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_wreg,
    input  logic       i_mem_memread,
    input  logic [4:0] i_mem_wreg,
    output logic       o_lu,
    output logic       o_je,
    output logic       o_jm
);

    logic w_ex_rs;
    logic w_ex_rt;
    logic w_mem_rs;

    assign w_ex_rs  = reg_match(i_ex_wreg, i_id_rs);
    assign w_ex_rt  = reg_match(i_ex_wreg, i_id_rt);
    assign w_mem_rs = reg_match(i_mem_wreg, i_id_rs);

    assign o_lu = i_ex_memread
                & ((i_id_use_rs & w_ex_rs) | (i_id_use_rt & w_ex_rt));
    assign o_je = i_id_jmp_reg & i_ex_memread & w_ex_rs;
    assign o_jm = i_id_jmp_reg & i_mem_memread & w_mem_rs;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer (load-use, jr-on-load, mult/div wait, MEM flush).
// Optional HAZARD_PERF_CNT_EN adds per-cause saturating stall-cycle counters.
import pipe_pkg::*;

module hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_Rs,
    input  logic [4:0] id_Rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_jmp_reg,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_wreg,
    input  logic       mem_MemRead,
    input  logic [4:0] mem_wreg,
    input  logic       ex_md_req,
    input  logic       md_done,
    input  logic       mem_flush,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       id_ex_bubble,
    output logic       ex_mem_bubble,
    output logic       if_id_flush,
    output logic       md_start,
    output logic       md_abort,
    output logic       md_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] jr_stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    hz_state_e    r_state;
    hz_state_e    w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    stage_ctrl_t  w_ctrl;
    stall_cause_e w_cause;
    logic         w_lu;
    logic         w_je;
    logic         w_jm;

    hazard_detect u_detect (
        .i_id_rs      (id_Rs),
        .i_id_rt      (id_Rt),
        .i_id_use_rs  (id_use_rs),
        .i_id_use_rt  (id_use_rt),
        .i_id_jmp_reg (id_jmp_reg),
        .i_ex_memread (ex_MemRead),
        .i_ex_wreg    (ex_wreg),
        .i_mem_memread(mem_MemRead),
        .i_mem_wreg   (mem_wreg),
        .o_lu         (w_lu),
        .o_je         (w_je),
        .o_jm         (w_jm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_ctrl     = CTRL_NOP;
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_cause    = CAUSE_NONE;
        if (mem_flush) begin
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
            w_ctrl.md_abort     = (r_state == ST_MD_WAIT);
            w_next              = ST_RUN;
            w_cnt_next          = '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (ex_md_req) begin
                        w_ctrl.pc_stall      = 1'b1;
                        w_ctrl.if_id_stall   = 1'b1;
                        w_ctrl.id_ex_stall   = 1'b1;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_ctrl.md_start      = 1'b1;
                        w_cause              = CAUSE_MD;
                        w_next               = ST_MD_WAIT;
                        w_cnt_next           = '0;
                    end else if (w_je || w_jm) begin
                        w_ctrl.pc_stall     = 1'b1;
                        w_ctrl.if_id_stall  = 1'b1;
                        w_ctrl.id_ex_bubble = 1'b1;
                        w_cause             = CAUSE_JR;
                        w_next              = w_je ? ST_JR_STALL : ST_RUN;
                    end else if (w_lu) begin
                        w_ctrl.pc_stall     = 1'b1;
                        w_ctrl.if_id_stall  = 1'b1;
                        w_ctrl.id_ex_bubble = 1'b1;
                        w_cause             = CAUSE_LU;
                        w_next              = ST_LU_STALL;
                    end
                end
                ST_LU_STALL: begin
                    w_next = ST_RUN;
                end
                ST_JR_STALL: begin
                    // load is in MEM here; after this cycle it is bypassed from WB
                    w_ctrl.pc_stall     = 1'b1;
                    w_ctrl.if_id_stall  = 1'b1;
                    w_ctrl.id_ex_bubble = 1'b1;
                    w_cause             = CAUSE_JR;
                    w_next              = ST_RUN;
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        w_next     = ST_RUN;
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_W'(MD_MAX_CYCLES - 1)) begin
                        w_ctrl.md_err   = 1'b1;
                        w_ctrl.md_abort = 1'b1;
                        w_next          = ST_RUN;
                        w_cnt_next      = '0;
                    end else begin
                        w_ctrl.pc_stall      = 1'b1;
                        w_ctrl.if_id_stall   = 1'b1;
                        w_ctrl.id_ex_stall   = 1'b1;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_cause              = CAUSE_MD;
                        w_cnt_next           = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end
    end

    assign pc_stall      = w_ctrl.pc_stall;
    assign if_id_stall   = w_ctrl.if_id_stall;
    assign id_ex_stall   = w_ctrl.id_ex_stall;
    assign id_ex_bubble  = w_ctrl.id_ex_bubble;
    assign ex_mem_bubble = w_ctrl.ex_mem_bubble;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign md_start      = w_ctrl.md_start;
    assign md_abort      = w_ctrl.md_abort;
    assign md_err        = w_ctrl.md_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_jr_cnt;
    logic [31:0] r_md_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_cnt <= '0;
            r_jr_cnt <= '0;
            r_md_cnt <= '0;
        end else begin
            if (w_cause == CAUSE_LU && r_lu_cnt != '1)
                r_lu_cnt <= r_lu_cnt + 32'd1;
            if (w_cause == CAUSE_JR && r_jr_cnt != '1)
                r_jr_cnt <= r_jr_cnt + 32'd1;
            if (w_cause == CAUSE_MD && r_md_cnt != '1)
                r_md_cnt <= r_md_cnt + 32'd1;
        end
    end

    assign lu_stall_cnt = r_lu_cnt;
    assign jr_stall_cnt = r_jr_cnt;
    assign md_stall_cnt = r_md_cnt;
`endif

endmodule
